// File: rtl/ysyx_25020037_alu_arb.sv
// Two-requester arbiter in front of one shared combinational ALU, holding one result per accept.
// Define YSYX_25020037_ALU_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module ysyx_25020037_alu_arb #(
  parameter int unsigned OP_W = 17
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req0_dcal,
  input  logic [127:0]      req0_src,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic              req1_dcal,
  input  logic [127:0]      req1_src,

  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [63:0]       resp0_res,

  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [63:0]       resp1_res,

  output logic [OP_W-1:0]   alu_op,
  output logic              alu_double_cal,
  output logic [127:0]      alu_src,
  input  logic [63:0]       alu_res
);

  localparam int unsigned SRC_W = 128;
  localparam int unsigned RES_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t             state_q;
  logic               owner_q;
  logic [RES_W-1:0]   res_q;

  logic               owner_ready;
  logic               can_issue;
  logic               grant_vld;
  logic               grant_id;
  logic               accept;

  // Issue slot opens when empty, or when the held result drains this cycle.
  always_comb begin
    owner_ready = owner_q ? resp1_ready : resp0_ready;
    can_issue   = 1'b0;
    if (!reset) begin
      can_issue = (state_q == IDLE) || owner_ready;
    end
  end

`ifdef YSYX_25020037_ALU_ARB_RR_EN
  logic rr_last_q;

  // On contention, grant whichever requester was not granted last.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~rr_last_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_last_q <= 1'b1;
    end else if (accept) begin
      rr_last_q <= grant_id;
    end
  end
`else
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = ~req0_valid & req1_valid;
  end
`endif

  always_comb begin
    accept     = can_issue & grant_vld;
    req0_ready = accept & ~grant_id;
    req1_ready = accept & grant_id;
  end

  // Shared ALU sees the granted requester's operation, zero when nobody asks.
  always_comb begin
    alu_op         = '0;
    alu_double_cal = 1'b0;
    alu_src        = '0;
    if (grant_vld) begin
      if (grant_id) begin
        alu_op         = req1_op;
        alu_double_cal = req1_dcal;
        alu_src        = SRC_W'(req1_src);
      end else begin
        alu_op         = req0_op;
        alu_double_cal = req0_dcal;
        alu_src        = SRC_W'(req0_src);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RESP;
            owner_q <= grant_id;
            res_q   <= RES_W'(alu_res);
          end
        end
        RESP: begin
          if (accept) begin
            owner_q <= grant_id;
            res_q   <= RES_W'(alu_res);
          end else if (owner_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    resp0_valid = (state_q == RESP) & ~owner_q;
    resp1_valid = (state_q == RESP) & owner_q;
    resp0_res   = res_q;
    resp1_res   = res_q;
  end

endmodule

// File: tb/tb_ysyx_25020037_alu_arb.sv
// Self-checking bench for ysyx_25020037_alu_arb: directed scenarios plus a randomized
// run against a transaction-level model of the arbiter and a toy ALU.
module tb_ysyx_25020037_alu_arb;

  localparam int unsigned OP_W = 17;

  logic              clock;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic              req0_dcal, req1_dcal;
  logic [127:0]      req0_src, req1_src;
  logic              resp0_valid, resp1_valid;
  logic              resp0_ready, resp1_ready;
  logic [63:0]       resp0_res, resp1_res;
  logic [OP_W-1:0]   alu_op;
  logic              alu_double_cal;
  logic [127:0]      alu_src;
  logic [63:0]       alu_res;

  int n_checks = 0;
  int n_fails  = 0;

  // Toy ALU: add/beq produce src1+src2; result2 is the branch condition for double_cal ops.
  function automatic logic [63:0] tb_alu(input logic [OP_W-1:0] op, input logic dcal,
                                         input logic [127:0] src);
    logic [31:0] s1, s2, s3, s4, r1, r2;
    s1 = src[31:0];
    s2 = src[63:32];
    s3 = src[95:64];
    s4 = src[127:96];
    if (op[0] || op[12]) r1 = s1 + s2;
    else r1 = s1 ^ s2 ^ 32'(op);
    r2 = dcal ? 32'(s3 == s4) : 32'h1;
    return {r2, r1};
  endfunction

  assign alu_res = tb_alu(alu_op, alu_double_cal, alu_src);

  ysyx_25020037_alu_arb #(.OP_W(OP_W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_dcal(req0_dcal), .req0_src(req0_src),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_dcal(req1_dcal), .req1_src(req1_src),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_res(resp0_res),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_res(resp1_res),
    .alu_op(alu_op), .alu_double_cal(alu_double_cal), .alu_src(alu_src),
    .alu_res(alu_res)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req0_op = '0; req0_dcal = 0; req0_src = '0;
    req1_valid = 0; req1_op = '0; req1_dcal = 0; req1_src = '0;
    resp0_ready = 0; resp1_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    req0_valid = 1; req0_op = 17'h00001;
    req1_valid = 1; req1_op = 17'h00002;
    resp0_ready = 1; resp1_ready = 1;
    cyc();
    #1;
    n_checks++; if (req0_ready !== 1'b0) begin n_fails++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
    n_checks++; if (req1_ready !== 1'b0) begin n_fails++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
    n_checks++; if (resp0_valid !== 1'b0) begin n_fails++; $display("FAIL reset_resp0_valid got=%b exp=0", resp0_valid); end
    n_checks++; if (resp1_valid !== 1'b0) begin n_fails++; $display("FAIL reset_resp1_valid got=%b exp=0", resp1_valid); end
    n_checks++; if (resp0_res !== 64'd0) begin n_fails++; $display("FAIL reset_res got=%h exp=0", resp0_res); end
    reset = 0;
    clear_inputs();
  endtask

  task automatic test_add();
    do_reset();
    req0_valid = 1; req0_op = 17'h00001; req0_dcal = 0;
    req0_src = {64'd0, 32'd7, 32'd5};
    #1;
    n_checks++; if (req0_ready !== 1'b1) begin n_fails++; $display("FAIL add_req0_ready got=%b exp=1", req0_ready); end
    n_checks++; if (req1_ready !== 1'b0) begin n_fails++; $display("FAIL add_req1_ready got=%b exp=0", req1_ready); end
    n_checks++; if (alu_op !== 17'h00001) begin n_fails++; $display("FAIL add_alu_op got=%h exp=00001", alu_op); end
    cyc();
    req0_valid = 0;
    #1;
    n_checks++; if (resp0_valid !== 1'b1) begin n_fails++; $display("FAIL add_resp0_valid got=%b exp=1", resp0_valid); end
    n_checks++; if (resp1_valid !== 1'b0) begin n_fails++; $display("FAIL add_resp1_valid got=%b exp=0", resp1_valid); end
    n_checks++; if (resp0_res !== {32'h1, 32'd12}) begin n_fails++; $display("FAIL add_res got=%h exp=%h", resp0_res, {32'h1, 32'd12}); end
    n_checks++; if (alu_op !== '0 || alu_src !== '0) begin n_fails++; $display("FAIL add_alu_idle_zero got op=%h src=%h exp=0", alu_op, alu_src); end
    resp0_ready = 1;
    cyc();
    #1;
    n_checks++; if (resp0_valid !== 1'b0) begin n_fails++; $display("FAIL add_drained got=%b exp=0", resp0_valid); end
    clear_inputs();
  endtask

  task automatic test_beq();
    do_reset();
    req0_valid = 1; req0_op = 17'h01000; req0_dcal = 1;
    req0_src = {32'd9, 32'd9, 32'h10, 32'h80000000};
    #1;
    n_checks++; if (req0_ready !== 1'b1) begin n_fails++; $display("FAIL beq_req0_ready got=%b exp=1", req0_ready); end
    n_checks++; if (alu_double_cal !== 1'b1) begin n_fails++; $display("FAIL beq_alu_dcal got=%b exp=1", alu_double_cal); end
    cyc();
    req0_valid = 0;
    #1;
    n_checks++; if (resp0_valid !== 1'b1) begin n_fails++; $display("FAIL beq_resp0_valid got=%b exp=1", resp0_valid); end
    n_checks++; if (resp0_res !== {32'h1, 32'h80000010}) begin n_fails++; $display("FAIL beq_res got=%h exp=%h", resp0_res, {32'h1, 32'h80000010}); end
    clear_inputs();
  endtask

  task automatic test_arbitration();
    int exp_g, prev_g;
    do_reset();
    req0_valid = 1; req0_op = 17'h00001; req0_src = {64'd0, 32'd1, 32'd2};
    req1_valid = 1; req1_op = 17'h00001; req1_src = {64'd0, 32'd100, 32'd200};
    resp0_ready = 1; resp1_ready = 1;
    prev_g = -1;
    for (int i = 0; i < 6; i++) begin
`ifdef YSYX_25020037_ALU_ARB_RR_EN
      exp_g = i % 2;
`else
      exp_g = 0;
`endif
      #1;
      n_checks++; if (req0_ready !== (exp_g == 0) || req1_ready !== (exp_g == 1)) begin
        n_fails++; $display("FAIL arb_grant_%0d got=%b%b exp_grant=%0d", i, req1_ready, req0_ready, exp_g); end
      if (prev_g >= 0) begin
        n_checks++; if (resp0_valid !== (prev_g == 0) || resp1_valid !== (prev_g == 1)) begin
          n_fails++; $display("FAIL arb_owner_%0d got=%b%b exp_owner=%0d", i, resp1_valid, resp0_valid, prev_g); end
        n_checks++; if (resp0_res !== ((prev_g == 0) ? {32'h1, 32'd3} : {32'h1, 32'd300})) begin
          n_fails++; $display("FAIL arb_res_%0d got=%h owner=%0d", i, resp0_res, prev_g); end
      end
      prev_g = exp_g;
      cyc();
    end
    clear_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    req0_valid = 1; req0_op = 17'h00001; req0_src = {64'd0, 32'd3, 32'd4};
    #1;
    n_checks++; if (req0_ready !== 1'b1) begin n_fails++; $display("FAIL stall_accept0 got=%b exp=1", req0_ready); end
    cyc();
    req0_valid = 0;
    req1_valid = 1; req1_op = 17'h00001; req1_src = {64'd0, 32'd10, 32'd20};
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (req1_ready !== 1'b0) begin n_fails++; $display("FAIL stall_req1_ready_%0d got=%b exp=0", k, req1_ready); end
      n_checks++; if (resp0_valid !== 1'b1 || resp0_res !== {32'h1, 32'd7}) begin
        n_fails++; $display("FAIL stall_hold_%0d got valid=%b res=%h exp valid=1 res=%h", k, resp0_valid, resp0_res, {32'h1, 32'd7}); end
      cyc();
    end
    resp0_ready = 1;
    #1;
    n_checks++; if (req1_ready !== 1'b1) begin n_fails++; $display("FAIL stall_refill got=%b exp=1", req1_ready); end
    cyc();
    req1_valid = 0; resp0_ready = 0;
    #1;
    n_checks++; if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0) begin
      n_fails++; $display("FAIL stall_new_owner got=%b%b exp=10", resp1_valid, resp0_valid); end
    n_checks++; if (resp1_res !== {32'h1, 32'd30}) begin n_fails++; $display("FAIL stall_new_res got=%h exp=%h", resp1_res, {32'h1, 32'd30}); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_resp();
    do_reset();
    req1_valid = 1; req1_op = 17'h00001; req1_src = {64'd0, 32'd1, 32'd2};
    #1;
    n_checks++; if (req1_ready !== 1'b1) begin n_fails++; $display("FAIL rmid_accept1 got=%b exp=1", req1_ready); end
    cyc();
    req1_valid = 0;
    #1;
    n_checks++; if (resp1_valid !== 1'b1) begin n_fails++; $display("FAIL rmid_resp1_valid got=%b exp=1", resp1_valid); end
    req0_valid = 1; req0_op = 17'h00001; req0_src = {64'd0, 32'd5, 32'd6};
    req1_valid = 1;
    #2;
    reset = 1;
    #1;
    n_checks++; if (resp1_valid !== 1'b0 || resp0_valid !== 1'b0) begin
      n_fails++; $display("FAIL rmid_discard got=%b%b exp=00", resp1_valid, resp0_valid); end
    n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fails++; $display("FAIL rmid_ready_in_reset got=%b%b exp=00", req1_ready, req0_ready); end
    n_checks++; if (resp1_res !== 64'd0) begin n_fails++; $display("FAIL rmid_res_cleared got=%h exp=0", resp1_res); end
    cyc();
    reset = 0;
    #1;
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fails++; $display("FAIL rmid_first_grant got=%b%b exp=01", req1_ready, req0_ready); end
    cyc();
    req0_valid = 0; req1_valid = 0;
    #1;
    n_checks++; if (resp0_valid !== 1'b1 || resp0_res !== {32'h1, 32'd11}) begin
      n_fails++; $display("FAIL rmid_post_res got valid=%b res=%h exp valid=1 res=%h", resp0_valid, resp0_res, {32'h1, 32'd11}); end
    clear_inputs();
  endtask

  task automatic test_random();
    bit              held, owner, rr_last, gv, g, can;
    bit              pend [2];
    bit              rdy  [2];
    logic [OP_W-1:0] op   [2];
    logic            dcal [2];
    logic [127:0]    src  [2];
    logic [63:0]     mres;
    logic [OP_W-1:0] exp_op;
    logic [127:0]    exp_src;
    do_reset();
    held = 0; owner = 0; rr_last = 1; mres = '0;
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && ($urandom_range(9) < 7)) begin
          pend[n] = 1;
          op[n]   = OP_W'(1) << $urandom_range(OP_W - 1);
          dcal[n] = 1'($urandom_range(1));
          src[n]  = {$urandom, $urandom, $urandom, $urandom};
        end
        rdy[n] = ($urandom_range(3) != 0);
      end
      req0_valid = pend[0]; req0_op = op[0]; req0_dcal = dcal[0]; req0_src = src[0];
      req1_valid = pend[1]; req1_op = op[1]; req1_dcal = dcal[1]; req1_src = src[1];
      resp0_ready = rdy[0]; resp1_ready = rdy[1];
      #1;
      // Expected behaviour from the transaction rules.
      can = !held || rdy[owner];
      gv  = pend[0] || pend[1];
`ifdef YSYX_25020037_ALU_ARB_RR_EN
      if (pend[0] && pend[1]) g = !rr_last;
      else g = !pend[0];
`else
      g = !pend[0];
`endif
      exp_op  = gv ? op[g]  : '0;
      exp_src = gv ? src[g] : '0;
      n_checks++; if (req0_ready !== (can && gv && !g) || req1_ready !== (can && gv && g)) begin
        n_fails++; $display("FAIL rnd_ready c=%0d got=%b%b exp=%b%b", c, req1_ready, req0_ready, can && gv && g, can && gv && !g); end
      n_checks++; if (resp0_valid !== (held && !owner) || resp1_valid !== (held && owner)) begin
        n_fails++; $display("FAIL rnd_resp_valid c=%0d got=%b%b exp=%b%b", c, resp1_valid, resp0_valid, held && owner, held && !owner); end
      if (held) begin
        n_checks++; if (resp0_res !== mres || resp1_res !== mres) begin
          n_fails++; $display("FAIL rnd_res c=%0d got=%h/%h exp=%h", c, resp0_res, resp1_res, mres); end
      end
      n_checks++; if (alu_op !== exp_op || alu_src !== exp_src) begin
        n_fails++; $display("FAIL rnd_alu_mux c=%0d got op=%h exp op=%h", c, alu_op, exp_op); end
      if (can && gv) begin
        held = 1; owner = g; mres = tb_alu(op[g], dcal[g], src[g]); rr_last = g; pend[g] = 0;
      end else if (held && rdy[owner]) begin
        held = 0;
      end
      cyc();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_add();
    test_beq();
    test_arbitration();
    test_stall();
    test_reset_mid_resp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
